imem_dmem_port_arbiter: RTL and testbench

- Arbiter and sequencer that shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
- Grants one access at a time and counts the memory's fixed read latency.
- Returns read data or a write acknowledge to the winning requester.
- Drives per-stage stall requests to the hazard logic while an access is pending.

---
 rtl/imem_dmem_port_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_imem_dmem_port_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_dmem_port_arbiter
//
// Shares one single-port unified memory between the fetch stage (instruction
// reads) and the memory stage (data loads/stores) of a 5-stage pipeline.
// One access is in flight at a time. The FSM walks IDLE -> BUSY -> RESP:
//   IDLE : grant a pending request and issue the memory command.
//   BUSY : count down the fixed memory read latency, then capture read data.
//   RESP : one-cycle valid pulse to the winner. No grant is made here, so a
//          requester that drops its request afterwards is never re-granted.
// Data requests win ties because they belong to the older instruction. After
// STARVE_LIMIT consecutive data grants made while fetch waited, fetch wins
// the next tie.
//
// Optional build macro: ARB_PERF_CNT_EN adds saturating 16-bit stall-cycle
// counters o_FetchWaitCnt / o_DataWaitCnt.
//
// Ports:
//   i_CLK, i_RST            clock (rising edge), synchronous active-high reset
//   i_FetchReq/i_FetchAddr  fetch request, held until o_FetchValid
//   o_FetchValid/o_FetchData  fetch response pulse and instruction word
//   i_DataReq/i_DataWe/i_DataAddr/i_DataWdata  data request (1 = store)
//   o_DataValid/o_DataRdata  load data valid or store acknowledge
//   o_StallF, o_StallM      stall requests to the hazard unit (combinational)
//   o_MemEn/o_MemWe/o_MemAddr/o_MemWdata  registered memory command
//   i_MemRdata              read data, valid MEM_LATENCY cycles after o_MemEn
//   o_FetchWaitCnt/o_DataWaitCnt  stall-cycle counters (ARB_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module imem_dmem_port_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int MEM_LATENCY   = 2,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     i_CLK,
    input  logic                     i_RST,
    input  logic                     i_FetchReq,
    input  logic [ADDRESS_WIDTH-1:0] i_FetchAddr,
    output logic                     o_FetchValid,
    output logic [DATA_WIDTH-1:0]    o_FetchData,
    input  logic                     i_DataReq,
    input  logic                     i_DataWe,
    input  logic [ADDRESS_WIDTH-1:0] i_DataAddr,
    input  logic [DATA_WIDTH-1:0]    i_DataWdata,
    output logic                     o_DataValid,
    output logic [DATA_WIDTH-1:0]    o_DataRdata,
    output logic                     o_StallF,
    output logic                     o_StallM,
    output logic                     o_MemEn,
    output logic                     o_MemWe,
    output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]    o_MemWdata,
    input  logic [DATA_WIDTH-1:0]    i_MemRdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]              o_FetchWaitCnt,
    output logic [15:0]              o_DataWaitCnt
`endif
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_ZERO   = LAT_W'(0);
    localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);
    localparam logic [STV_W-1:0] STV_ZERO   = STV_W'(0);
    localparam logic [STV_W-1:0] STV_ONE    = STV_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t                   state_r,       state_s;
    owner_t                   owner_r,       owner_s;
    logic [LAT_W-1:0]         lat_cnt_r,     lat_cnt_s;
    logic [STV_W-1:0]         starve_cnt_r,  starve_cnt_s;
    logic                     mem_en_r,      mem_en_s;
    logic                     mem_we_r,      mem_we_s;
    logic [ADDRESS_WIDTH-1:0] mem_addr_r,    mem_addr_s;
    logic [DATA_WIDTH-1:0]    mem_wdata_r,   mem_wdata_s;
    logic                     fetch_valid_r, fetch_valid_s;
    logic                     data_valid_r,  data_valid_s;
    logic [DATA_WIDTH-1:0]    fetch_data_r,  fetch_data_s;
    logic [DATA_WIDTH-1:0]    data_rdata_r,  data_rdata_s;

    // Next-state and next-output logic for the arbiter FSM.
    always_comb begin
        state_s       = state_r;
        owner_s       = owner_r;
        lat_cnt_s     = lat_cnt_r;
        starve_cnt_s  = starve_cnt_r;
        mem_en_s      = 1'b0;
        mem_we_s      = mem_we_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        fetch_valid_s = 1'b0;
        data_valid_s  = 1'b0;
        fetch_data_s  = fetch_data_r;
        data_rdata_s  = data_rdata_r;

        case (state_r)
            ST_IDLE: begin
                // Fetch wins if it is alone, or if data has been favoured
                // STARVE_LIMIT times in a row while fetch was waiting.
                if (i_FetchReq && (!i_DataReq || (starve_cnt_r >= STARVE_MAX))) begin
                    state_s      = ST_BUSY;
                    owner_s      = OWN_FETCH;
                    lat_cnt_s    = LAT_INIT;
                    starve_cnt_s = STV_ZERO;
                    mem_en_s     = 1'b1;
                    mem_we_s     = 1'b0;
                    mem_addr_s   = i_FetchAddr;
                    mem_wdata_s  = i_DataWdata;
                end else if (i_DataReq) begin
                    state_s     = ST_BUSY;
                    owner_s     = OWN_DATA;
                    lat_cnt_s   = LAT_INIT;
                    mem_en_s    = 1'b1;
                    mem_we_s    = i_DataWe;
                    mem_addr_s  = i_DataAddr;
                    mem_wdata_s = i_DataWdata;
                    // Cannot overflow: at STARVE_MAX a waiting fetch wins.
                    if (i_FetchReq) begin
                        starve_cnt_s = starve_cnt_r + STV_ONE;
                    end else begin
                        starve_cnt_s = STV_ZERO;
                    end
                end else begin
                    starve_cnt_s = STV_ZERO;
                end
            end
            ST_BUSY: begin
                if (lat_cnt_r == LAT_ZERO) begin
                    state_s = ST_RESP;
                    if (owner_r == OWN_FETCH) begin
                        fetch_valid_s = 1'b1;
                        fetch_data_s  = i_MemRdata;
                    end else begin
                        data_valid_s = 1'b1;
                        // A store acknowledge leaves the load data register alone.
                        if (!mem_we_r) begin
                            data_rdata_s = i_MemRdata;
                        end else begin
                            data_rdata_s = data_rdata_r;
                        end
                    end
                end else begin
                    lat_cnt_s = lat_cnt_r - LAT_ONE;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_r       <= ST_IDLE;
            owner_r       <= OWN_FETCH;
            lat_cnt_r     <= LAT_ZERO;
            starve_cnt_r  <= STV_ZERO;
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= {ADDRESS_WIDTH{1'b0}};
            mem_wdata_r   <= {DATA_WIDTH{1'b0}};
            fetch_valid_r <= 1'b0;
            data_valid_r  <= 1'b0;
            fetch_data_r  <= {DATA_WIDTH{1'b0}};
            data_rdata_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            owner_r       <= owner_s;
            lat_cnt_r     <= lat_cnt_s;
            starve_cnt_r  <= starve_cnt_s;
            mem_en_r      <= mem_en_s;
            mem_we_r      <= mem_we_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
            fetch_valid_r <= fetch_valid_s;
            data_valid_r  <= data_valid_s;
            fetch_data_r  <= fetch_data_s;
            data_rdata_r  <= data_rdata_s;
        end
    end

    assign o_FetchValid = fetch_valid_r;
    assign o_FetchData  = fetch_data_r;
    assign o_DataValid  = data_valid_r;
    assign o_DataRdata  = data_rdata_r;
    assign o_MemEn      = mem_en_r;
    assign o_MemWe      = mem_we_r;
    assign o_MemAddr    = mem_addr_r;
    assign o_MemWdata   = mem_wdata_r;
    assign o_StallF     = i_FetchReq & ~fetch_valid_r;
    assign o_StallM     = i_DataReq  & ~data_valid_r;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] fetch_wait_r;
    logic [15:0] data_wait_r;

    // Saturating stall-cycle counters.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            fetch_wait_r <= 16'h0000;
            data_wait_r  <= 16'h0000;
        end else begin
            if (o_StallF && (fetch_wait_r != 16'hFFFF)) begin
                fetch_wait_r <= fetch_wait_r + 16'h0001;
            end else begin
                fetch_wait_r <= fetch_wait_r;
            end
            if (o_StallM && (data_wait_r != 16'hFFFF)) begin
                data_wait_r <= data_wait_r + 16'h0001;
            end else begin
                data_wait_r <= data_wait_r;
            end
        end
    end

    assign o_FetchWaitCnt = fetch_wait_r;
    assign o_DataWaitCnt  = data_wait_r;
`endif

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for imem_dmem_port_arbiter (MEM_LATENCY=2, STARVE_LIMIT=2).
// A directed vector table, hand-written corner sequences and a randomized
// phase, all checked cycle by cycle against a transaction-level model that
// works from grant times: command at grant+1, capture at grant+L+1,
// valid at grant+L+2, arbiter free again at grant+L+3.
// -----------------------------------------------------------------------------
module tb_imem_dmem_port_arbiter;

    localparam int L  = 2;
    localparam int SL = 2;

    logic        i_CLK;
    logic        i_RST;
    logic        i_FetchReq;
    logic [31:0] i_FetchAddr;
    logic        o_FetchValid;
    logic [31:0] o_FetchData;
    logic        i_DataReq;
    logic        i_DataWe;
    logic [31:0] i_DataAddr;
    logic [31:0] i_DataWdata;
    logic        o_DataValid;
    logic [31:0] o_DataRdata;
    logic        o_StallF;
    logic        o_StallM;
    logic        o_MemEn;
    logic        o_MemWe;
    logic [31:0] o_MemAddr;
    logic [31:0] o_MemWdata;
    logic [31:0] i_MemRdata;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] o_FetchWaitCnt;
    logic [15:0] o_DataWaitCnt;
`endif

    imem_dmem_port_arbiter #(
        .DATA_WIDTH   (32),
        .ADDRESS_WIDTH(32),
        .MEM_LATENCY  (L),
        .STARVE_LIMIT (SL)
    ) dut (
        .i_CLK       (i_CLK),
        .i_RST       (i_RST),
        .i_FetchReq  (i_FetchReq),
        .i_FetchAddr (i_FetchAddr),
        .o_FetchValid(o_FetchValid),
        .o_FetchData (o_FetchData),
        .i_DataReq   (i_DataReq),
        .i_DataWe    (i_DataWe),
        .i_DataAddr  (i_DataAddr),
        .i_DataWdata (i_DataWdata),
        .o_DataValid (o_DataValid),
        .o_DataRdata (o_DataRdata),
        .o_StallF    (o_StallF),
        .o_StallM    (o_StallM),
        .o_MemEn     (o_MemEn),
        .o_MemWe     (o_MemWe),
        .o_MemAddr   (o_MemAddr),
        .o_MemWdata  (o_MemWdata),
        .i_MemRdata  (i_MemRdata)
`ifdef ARB_PERF_CNT_EN
        ,
        .o_FetchWaitCnt(o_FetchWaitCnt),
        .o_DataWaitCnt (o_DataWaitCnt)
`endif
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Transaction-level reference model state.
    bit          m_active  = 1'b0;
    bit          m_owner_d = 1'b0;
    bit          m_we      = 1'b0;
    int          m_g       = 0;
    int          m_starve  = 0;
    logic [31:0] m_addr    = 32'h0;
    logic [31:0] m_memaddr = 32'h0;
    logic [31:0] m_memwd   = 32'h0;
    logic [31:0] m_fdata   = 32'h0;
    logic [31:0] m_drdata  = 32'h0;
    int          m_fwait   = 0;
    int          m_dwait   = 0;
    bit          last_fv   = 1'b0;
    bit          last_dv   = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h8C01_0004;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Memory: returns mem_rd(addr) exactly L cycles after the command cycle,
    // random garbage in every other cycle.
    initial begin : mem_responder
        logic        pe [L];
        logic [31:0] pa [L];
        for (int i = 0; i < L; i++) begin
            pe[i] = 1'b0;
            pa[i] = 32'h0;
        end
        i_MemRdata = 32'h0;
        forever begin
            @(negedge i_CLK);
            for (int i = L - 1; i > 0; i--) begin
                pe[i] = pe[i-1];
                pa[i] = pa[i-1];
            end
            pe[0] = o_MemEn;
            pa[0] = o_MemAddr;
            @(posedge i_CLK);
            #1;
            if (pe[L-1] === 1'b1) i_MemRdata = mem_rd(pa[L-1]);
            else                  i_MemRdata = $urandom;
        end
    end

    // Compare the current cycle against the model, then advance the model
    // across the clock edge that ends this cycle.
    task automatic model_step(input bit do_chk);
        bit e_en, e_fv, e_dv;
        e_en = m_active && (cyc == m_g + 1);
        e_fv = m_active && !m_owner_d && (cyc == m_g + L + 2);
        e_dv = m_active &&  m_owner_d && (cyc == m_g + L + 2);
        if (do_chk) begin
            chk1 ("fetch_valid", o_FetchValid, e_fv);
            chk1 ("data_valid",  o_DataValid,  e_dv);
            chk1 ("stall_f",     o_StallF,     i_FetchReq & ~e_fv);
            chk1 ("stall_m",     o_StallM,     i_DataReq  & ~e_dv);
            chk1 ("mem_en",      o_MemEn,      e_en);
            if (e_en)          chk1 ("mem_we",    o_MemWe,    m_we);
            if (e_en && m_we)  chk32("mem_wdata", o_MemWdata, m_memwd);
            chk32("mem_addr",    o_MemAddr,    m_memaddr);
            chk32("fetch_data",  o_FetchData,  m_fdata);
            chk32("data_rdata",  o_DataRdata,  m_drdata);
`ifdef ARB_PERF_CNT_EN
            chk32("fetch_wait_cnt", 32'(o_FetchWaitCnt), 32'(m_fwait));
            chk32("data_wait_cnt",  32'(o_DataWaitCnt),  32'(m_dwait));
`endif
        end
        last_fv = e_fv;
        last_dv = e_dv;
        if (i_RST) begin
            m_fwait = 0;
            m_dwait = 0;
        end else begin
            if (i_FetchReq && !e_fv && m_fwait < 65535) m_fwait++;
            if (i_DataReq  && !e_dv && m_dwait < 65535) m_dwait++;
        end
        if (i_RST) begin
            m_active = 1'b0; m_owner_d = 1'b0; m_we = 1'b0; m_starve = 0;
            m_memaddr = 32'h0; m_memwd = 32'h0; m_fdata = 32'h0; m_drdata = 32'h0;
        end else if (m_active) begin
            if (cyc == m_g + L + 1 && !m_we) begin
                if (m_owner_d) m_drdata = mem_rd(m_addr);
                else           m_fdata  = mem_rd(m_addr);
            end
            if (cyc == m_g + L + 2) m_active = 1'b0;
        end else begin
            if (i_FetchReq && (!i_DataReq || m_starve >= SL)) begin
                m_active = 1'b1; m_g = cyc; m_owner_d = 1'b0; m_we = 1'b0;
                m_addr = i_FetchAddr; m_memwd = i_DataWdata; m_starve = 0;
            end else if (i_DataReq) begin
                m_active = 1'b1; m_g = cyc; m_owner_d = 1'b1; m_we = i_DataWe;
                m_addr = i_DataAddr; m_memwd = i_DataWdata;
                m_starve = i_FetchReq ? m_starve + 1 : 0;
            end else begin
                m_starve = 0;
            end
            if (m_active) m_memaddr = m_addr;
        end
        cyc++;
    endtask

    task automatic drive(input logic rst, input logic fr, input logic [31:0] fa,
                         input logic dr, input logic dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        @(posedge i_CLK);
        #1;
        i_RST = rst; i_FetchReq = fr; i_FetchAddr = fa;
        i_DataReq = dr; i_DataWe = dwe; i_DataAddr = da; i_DataWdata = dwd;
        @(negedge i_CLK);
    endtask

    task automatic step(input logic rst, input logic fr, input logic [31:0] fa,
                        input logic dr, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd);
        drive(rst, fr, fa, dr, dwe, da, dwd);
        model_step(1'b1);
    endtask

    task automatic settle();
        for (int k = 0; k < 20 && m_active; k++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        fr;
        logic [31:0] fa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        e_fv;
        logic        e_dv;
        logic        e_sf;
        logic        e_sm;
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_fdata;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] s3_exp [6];

    initial begin
        int          dv_at, fv_at, n_valid;
        logic        fon, don;
        logic [31:0] gq [$];

        // Fetch read at 0x40, then a store of 0xDEADBEEF to 0x200 whose
        // address/data inputs change after the grant edge.
        vecs[0]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h0,   32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004, 32'h0};
        vecs[6]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40,  32'h0,        32'h8C010004, 32'h0};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h3FC, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h8C010004, 32'h0};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h3FC, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,        32'h8C010004, 32'h0};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h3FC, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,        32'h8C010004, 32'h0};
        vecs[10] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h3FC, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0,        32'h8C010004, 32'h0};
        vecs[11] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0,        32'h8C010004, 32'h0};
        s3_exp = '{32'h104, 32'h104, 32'h44, 32'h104, 32'h104, 32'h44};

        i_RST = 1'b1; i_FetchReq = 1'b0; i_FetchAddr = 32'h0;
        i_DataReq = 1'b0; i_DataWe = 1'b0; i_DataAddr = 32'h0; i_DataWdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            model_step(1'b0);
        end

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
            chk1 ("tbl_fetch_valid", o_FetchValid, vecs[i].e_fv);
            chk1 ("tbl_data_valid",  o_DataValid,  vecs[i].e_dv);
            chk1 ("tbl_stall_f",     o_StallF,     vecs[i].e_sf);
            chk1 ("tbl_stall_m",     o_StallM,     vecs[i].e_sm);
            chk1 ("tbl_mem_en",      o_MemEn,      vecs[i].e_en);
            chk32("tbl_mem_addr",    o_MemAddr,    vecs[i].e_addr);
            chk32("tbl_fetch_data",  o_FetchData,  vecs[i].e_fdata);
            chk32("tbl_data_rdata",  o_DataRdata,  vecs[i].e_drdata);
            if (vecs[i].e_en) chk1("tbl_mem_we", o_MemWe, vecs[i].e_we);
            if (vecs[i].e_en && vecs[i].e_we) chk32("tbl_mem_wdata", o_MemWdata, vecs[i].e_wdata);
            model_step(1'b1);
        end

        // Simultaneous requests: data first (valid at +4), fetch next (+9).
        settle();
        dv_at = -1; fv_at = -1; fon = 1'b1; don = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step(1'b0, fon, 32'h80, don, 1'b0, 32'h100, 32'h0);
            if (o_DataValid === 1'b1 && dv_at < 0) begin dv_at = k; don = 1'b0; end
            if (o_FetchValid === 1'b1 && fv_at < 0) begin fv_at = k; fon = 1'b0; end
        end
        chk32("s2_data_valid_cycle",  32'(dv_at), 32'd4);
        chk32("s2_fetch_valid_cycle", 32'(fv_at), 32'd9);

        // Starvation limit with both requests held: D, D, F, D, D, F.
        settle();
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h104, 32'h0);
            if (o_MemEn === 1'b1) gq.push_back(o_MemAddr);
        end
        for (int i = 0; i < 6; i++) chk32("s3_grant_order", (i < gq.size()) ? gq[i] : 32'hFFFF_FFFF, s3_exp[i]);
        settle();

        // Reset in the second BUSY cycle abandons the access.
        step(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
        n_valid = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (k == 0) chk32("s5_fetch_data_reset", o_FetchData, 32'h0);
            if (o_FetchValid === 1'b1 || o_DataValid === 1'b1) n_valid++;
        end
        chk32("s5_no_valid_after_reset", 32'(n_valid), 32'd0);
        fv_at = -1; fon = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, fon, 32'h4C, 1'b0, 1'b0, 32'h0, 32'h0);
            if (o_FetchValid === 1'b1 && fv_at < 0) begin fv_at = k; fon = 1'b0; end
        end
        chk32("s5_resume_latency", 32'(fv_at), 32'd4);
        chk32("s5_resume_data",    o_FetchData, mem_rd(32'h4C));

        // Randomized traffic with occasional resets and early request drops.
        fon = 1'b0; don = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            logic rst;
            if (last_fv) fon = 1'b0;
            if (last_dv) don = 1'b0;
            if (!fon) fon = ($urandom_range(0, 2) == 0);
            else if (!(m_active && !m_owner_d) && $urandom_range(0, 39) == 0) fon = 1'b0;
            if (!don) don = ($urandom_range(0, 2) == 0);
            else if (!(m_active && m_owner_d) && $urandom_range(0, 39) == 0) don = 1'b0;
            rst = ($urandom_range(0, 149) == 0);
            step(rst, fon, $urandom, don, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end

`ifdef ARB_PERF_CNT_EN
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk32("perf_fetch_wait_4", 32'(o_FetchWaitCnt), 32'd4);
        for (int k = 0; k < 72000; k++) step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0);
        chk32("perf_fetch_wait_sat", 32'(o_FetchWaitCnt), 32'h0000_FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
